// File: rtl/urna_pkg.sv
// Shared types and constants for the ballot-box keypad front end.
// Holds the FSM state encoding, default timing constants and candidate codes.
package urna_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam int DEB_CYCLES_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 1000;
  localparam int DIGIT_W            = 4;
  localparam int NUM_KEYS           = 10;
  localparam int NUM_LINES          = NUM_KEYS + 1;  // digit keys plus cancel (MSB)

  // Candidate codes as expected by the downstream vote decoder.
  localparam logic [DIGIT_W-1:0] CAND_1 = 4'd1;
  localparam logic [DIGIT_W-1:0] CAND_2 = 4'd2;
  localparam logic [DIGIT_W-1:0] CAND_3 = 4'd3;

  function automatic logic one_hot(input logic [NUM_KEYS-1:0] keys);
    return (keys != '0) && ((keys & (keys - 1'b1)) == '0);
  endfunction

  function automatic logic [DIGIT_W-1:0] key_index(input logic [NUM_KEYS-1:0] keys);
    logic [DIGIT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) idx = DIGIT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/teclado_urna_if.sv
// Keypad interface: raw key lines in, decoded digit/event pulses out.
// The slave modport is the keypad decoder, the master modport is its user.
interface teclado_urna_if;
  import urna_pkg::*;

  logic [NUM_KEYS-1:0] key_raw;
  logic                cancel_raw;
  logic [DIGIT_W-1:0]  digit;
  logic                valid;
  logic                pos;
  logic                cancel;
  logic                err;
  logic                timeout;

  modport master (
    output key_raw, cancel_raw,
    input  digit, valid, pos, cancel, err, timeout
  );

  modport slave (
    input  key_raw, cancel_raw,
    output digit, valid, pos, cancel, err, timeout
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs, parameterized by width.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments make meta and q sample together, giving two real stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/teclado_urna.sv
// Ballot-box keypad decoder: synchronize, debounce, classify and emit key events.
// Optional partial-entry timeout is built only when TECLADO_TIMEOUT_EN is defined.
module teclado_urna
  import urna_pkg::*;
#(
  parameter int DEB_CYCLES     = DEB_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  teclado_urna_if.slave  bus
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  if (DEB_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("teclado_urna: DEB_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  logic [NUM_LINES-1:0] lines;

  sync2 #(.WIDTH(NUM_LINES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({bus.cancel_raw, bus.key_raw}),
    .q   (lines)
  );

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pos_q, pos_d;
  logic [DIGIT_W-1:0]   digit_q, digit_d;
  logic                 valid_q, valid_d;
  logic                 cancel_q, cancel_d;
  logic                 err_q, err_d;

`ifdef TECLADO_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              timeout_q, timeout_d;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    digit_d  = digit_q;
    valid_d  = 1'b0;
    cancel_d = 1'b0;
    err_d    = 1'b0;
`ifdef TECLADO_TIMEOUT_EN
    tcnt_d    = '0;
    timeout_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (|lines) begin
          state_d = DEBOUNCE;
          cand_d  = lines;
          cnt_d   = '0;
        end
`ifdef TECLADO_TIMEOUT_EN
        // A press in this cycle wins over an expiring partial entry.
        else if (pos_q) begin
          if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            pos_d     = 1'b0;
          end else begin
            tcnt_d = (&tcnt_q) ? tcnt_q : tcnt_q + 1'b1;
          end
        end
`endif
      end

      DEBOUNCE: begin
        if (lines == '0) begin
          state_d = IDLE;
        end else if (lines != cand_q) begin
          cand_d = lines;
          cnt_d  = '0;
        end else if (cnt_q == CNT_W'(DEB_CYCLES)) begin
          state_d = EMIT;
          // Cancel outranks digits; several digits at once are rejected.
          if (cand_q[NUM_LINES-1]) begin
            cancel_d = 1'b1;
            pos_d    = 1'b0;
          end else if (one_hot(cand_q[NUM_KEYS-1:0])) begin
            valid_d = 1'b1;
            digit_d = key_index(cand_q[NUM_KEYS-1:0]);
            pos_d   = ~pos_q;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
      end

      EMIT: begin
        state_d = WAIT_REL;
        cnt_d   = '0;
      end

      WAIT_REL: begin
        if (|lines) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      pos_q    <= 1'b0;
      digit_q  <= '0;
      valid_q  <= 1'b0;
      cancel_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef TECLADO_TIMEOUT_EN
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      digit_q  <= digit_d;
      valid_q  <= valid_d;
      cancel_q <= cancel_d;
      err_q    <= err_d;
`ifdef TECLADO_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.digit  = digit_q;
  assign bus.valid  = valid_q;
  assign bus.pos    = pos_q;
  assign bus.cancel = cancel_q;
  assign bus.err    = err_q;
`ifdef TECLADO_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: doc/teclado_urna.md
TECLADO_URNA -- requirements
Module: teclado_urna

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive synchronized-stable cycles needed to accept a press or a release.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: idle cycles allowed after a first digit before the partial entry is dropped.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 key_raw  input  10  asynchronous raw keypad lines; bit i is digit key i (0-9).
REQ-006 cancel_raw  input  1  asynchronous raw cancel key.
REQ-007 digit  output  4  binary code of the last accepted key; held until the next accept.
REQ-008 valid  output  1  one-cycle pulse; digit is valid in the same cycle.
REQ-009 pos  output  1  digit index within a vote: 0 means first digit, 1 means second; reflects the position of the next key.
REQ-010 cancel  output  1  one-cycle pulse when cancel is accepted.
REQ-011 err  output  1  one-cycle pulse when a multi-key press is rejected.
REQ-012 timeout  output  1  one-cycle pulse when a partial entry expires.

Function
REQ-013 Every raw input passes through a 2-flop synchronizer before any use.
REQ-014 FSM states: IDLE, DEBOUNCE, EMIT, WAIT_REL.
- IDLE: any synchronized key or cancel high -> DEBOUNCE; latch the candidate and clear the counter.
REQ-015 DEBOUNCE behaviour:
- Candidate unchanged: increment the counter.
- Candidate changed: restart the counter with the new candidate.
- All lines low: go back to IDLE.
- Counter reaches DEB_CYCLES: go to EMIT.
REQ-016 EMIT lasts exactly one cycle, then goes to WAIT_REL.
- Single digit key: valid=1, digit=key index, pos toggles (1 wraps to 0).
- Cancel: cancel=1 and pos=0.
- Two or more lines high: err=1, no valid, pos unchanged.
REQ-017 Cancel has priority: if cancel is high together with digit keys, treat it as a cancel with no err.
REQ-018 WAIT_REL returns to IDLE only after all synchronized lines are low for DEB_CYCLES consecutive cycles; presses during WAIT_REL are ignored.
REQ-019 Latency: raw key stable high from sample edge N gives valid high in cycle N+2+DEB_CYCLES+1.
REQ-020 Timeout: a counter runs while pos=1 and the FSM is in IDLE; reaching TIMEOUT_CYCLES pulses timeout, sets pos=0 and clears the counter.
REQ-021 The timeout counter clears on any transition out of IDLE; a timeout and a press in the same cycle resolve in favour of the press.
REQ-022 Counter widths: $clog2(DEB_CYCLES+1) and $clog2(TIMEOUT_CYCLES+1); counters saturate and never wrap.

Reset
REQ-023 rst=1 at posedge: state=IDLE, all counters=0, pos=0, digit=4'h0, valid=cancel=err=timeout=0, synchronizer flops=0.
REQ-024 Reset mid-debounce or mid-EMIT aborts with no pulse emitted; a key still held after reset must debounce from zero.

Configuration
REQ-025 Macro TECLADO_TIMEOUT_EN.
- Defined: the timeout counter and REQ-020/021 behaviour are present.
- Undefined: no timeout counter is built, timeout is tied to 0, and pos changes only on valid, cancel or reset.

Structure
REQ-026 Package urna_pkg holds:
- the FSM state typedef (2-bit enum);
- DEB_CYCLES and TIMEOUT_CYCLES default constants;
- the digit width constant (4);
- candidate code constants for digits 1, 2 and 3, matching the downstream vote decoder.
REQ-027 One sub-module, sync2: a 2-flop synchronizer, parameterized by width, instantiated once for the 11 raw lines.

Verification
REQ-028 Raw key 3 held for 20 cycles, DEB_CYCLES=4 -> exactly one valid pulse in cycle N+7, digit=4'd3, pos goes 0->1.
REQ-029 Key 1 held with 2-cycle glitches before it stabilizes -> only one valid pulse, counted from the final stable edge; no err.
REQ-030 Keys 1 and 2 pressed together and held -> err pulse once, no valid, pos unchanged; a new press is accepted only after release.
REQ-031 Key 2 accepted, then no keys for TIMEOUT_CYCLES=16 with TECLADO_TIMEOUT_EN defined -> timeout pulse on idle cycle 16, pos=0. With the macro undefined -> no pulse, pos stays 1.
REQ-032 Cancel and key 5 held together after one digit -> cancel pulse, pos=0, no valid, no err.
REQ-033 rst asserted while key 7 is mid-debounce and key stays held -> no valid during reset; valid arrives DEB_CYCLES+3 cycles after rst deasserts.
